// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the character-LCD message writer.
// Instruction codes follow the HD44780 command set used by the Avalon char LCD controller.
package lcd_pkg;

   localparam logic [7:0] INSTR_CLEAR = 8'h01;
   localparam logic [7:0] INSTR_ROW0  = 8'h80;
   localparam logic [7:0] INSTR_ROW1  = 8'hC0;
   localparam logic [7:0] CHAR_SPACE  = 8'h20;

   localparam logic ADDR_INSTR = 1'b0;
   localparam logic ADDR_DATA  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ROW_ADDR,
      CHAR,
      GAP,
      FINISH
   } state_t;

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational message store: one 16-character line per (message, row).
// Any message, row or column outside the configured display returns a space.
module lcd_msg_rom
   import lcd_pkg::*;
#(
   parameter int N_MSG  = 4,
   parameter int N_COLS = 16,
   parameter int N_ROWS = 2,
   parameter int MSG_W  = 2,
   parameter int COL_W  = 4
) (
   input  logic [MSG_W-1:0] msg_i,
   input  logic             row_i,
   input  logic [COL_W-1:0] col_i,
   output logic [7:0]       char_o
);

   logic [15:0][7:0] line;

   function automatic logic [15:0][7:0] line_text(input int msg, input logic row);
      case (msg)
         0:       line_text = row ? "LCD MSG WRITER  " : "HELLO, WORLD!   ";
         1:       line_text = row ? "SECOND LINE 1   " : "MESSAGE ONE     ";
         2:       line_text = row ? "SECOND LINE 2   " : "MESSAGE TWO     ";
         3:       line_text = row ? "0123456789ABCDEF" : "STATUS: READY   ";
         4:       line_text = row ? "abcdefghijklmnop" : "ALARM: CHECK IO ";
         default: line_text = {16{CHAR_SPACE}};
      endcase
   endfunction

   // NOTE: char_o gets a default before the conditional so no latch is inferred.
   always_comb begin
      line   = line_text(int'(msg_i), row_i);
      char_o = CHAR_SPACE;
      if (int'(msg_i) < N_MSG && int'(row_i) < N_ROWS &&
          int'(col_i) < N_COLS && int'(col_i) < 16) begin
         char_o = line[4'(15 - int'(col_i))];
      end
   end

endmodule

// File: rtl/lcd_msg_writer.sv
// Writes a selected ROM message to an Avalon-MM character LCD controller:
// optional clear, then per row an address instruction followed by N_COLS data writes.
module lcd_msg_writer
   import lcd_pkg::*;
#(
   parameter int N_MSG           = 4,
   parameter int N_COLS          = 16,
   parameter int N_ROWS          = 2,
   parameter int CLEAR_ON_UPDATE = 1,
   parameter int AUTO_UPDATE     = 1,
   parameter int WAIT_TIMEOUT    = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [$clog2(N_MSG)-1:0] msg_sel,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic                     address,
   output logic                     chipselect,
   output logic                     write,
   output logic [7:0]               writedata,
   input  logic                     waitrequest
);

   localparam int MSG_W  = $clog2(N_MSG);
   localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int WAIT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(N_COLS - 1);
   localparam logic              LAST_ROW   = 1'(N_ROWS - 1);

   state_t            state_q, next_q;
   logic [MSG_W-1:0]  msg_q, last_q;
   logic              last_vld_q, pending_q, row_q;
   logic [COL_W-1:0]  col_q;
   logic [WAIT_W-1:0] wait_q;
   logic              busy_q, done_q, error_q, cs_q, wr_q, addr_q;
   logic [7:0]        wdata_q;
   logic [7:0]        rom_char;
   logic              idle_trig, busy_trig, launch;

   lcd_msg_rom #(
      .N_MSG (N_MSG),
      .N_COLS(N_COLS),
      .N_ROWS(N_ROWS),
      .MSG_W (MSG_W),
      .COL_W (COL_W)
   ) u_rom (
      .msg_i (msg_q),
      .row_i (row_q),
      .col_i (col_q),
      .char_o(rom_char)
   );

   // While busy a message change is judged against the message being drawn, not the old one.
   always_comb begin
      idle_trig = start || !last_vld_q || ((AUTO_UPDATE != 0) && (msg_sel != last_q));
      busy_trig = start || ((AUTO_UPDATE != 0) && (msg_sel != msg_q));
      launch    = ((state_q == IDLE) && idle_trig) ||
                  ((state_q == FINISH) && (pending_q || busy_trig));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         next_q     <= IDLE;
         msg_q      <= '0;
         last_q     <= '0;
         last_vld_q <= 1'b0;
         pending_q  <= 1'b0;
         row_q      <= 1'b0;
         col_q      <= '0;
         wait_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cs_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= ADDR_INSTR;
         wdata_q    <= 8'h00;
      end else begin
         done_q <= 1'b0;
         if (start) error_q <= 1'b0;

         case (state_q)
            IDLE: ;
            CLEAR, ROW_ADDR, CHAR: begin
               if (busy_trig) pending_q <= 1'b1;
               if (!waitrequest) begin
                  cs_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  wait_q  <= '0;
                  state_q <= GAP;
                  case (state_q)
                     CLEAR:    next_q <= ROW_ADDR;
                     ROW_ADDR: begin
                        col_q  <= '0;
                        next_q <= CHAR;
                     end
                     default: begin
                        if (col_q != LAST_COL) begin
                           col_q  <= col_q + 1'b1;
                           next_q <= CHAR;
                        end else if (row_q != LAST_ROW) begin
                           row_q  <= 1'b1;
                           next_q <= ROW_ADDR;
                        end else begin
                           next_q <= FINISH;
                        end
                     end
                  endcase
               end else if (wait_q == WAIT_LIMIT) begin
                  // Abort counts as displayed so auto-update does not spin on a dead controller.
                  cs_q       <= 1'b0;
                  wr_q       <= 1'b0;
                  wait_q     <= '0;
                  error_q    <= 1'b1;
                  pending_q  <= 1'b0;
                  busy_q     <= 1'b0;
                  last_q     <= msg_q;
                  last_vld_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            GAP: begin
               if (busy_trig) pending_q <= 1'b1;
               state_q <= next_q;
               if (next_q == FINISH) begin
                  done_q <= 1'b1;
               end else begin
                  cs_q    <= 1'b1;
                  wr_q    <= 1'b1;
                  addr_q  <= (next_q == CHAR) ? ADDR_DATA : ADDR_INSTR;
                  wdata_q <= (next_q == CHAR) ? rom_char : (row_q ? INSTR_ROW1 : INSTR_ROW0);
               end
            end
            FINISH: begin
               busy_q     <= 1'b0;
               last_q     <= msg_q;
               last_vld_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // NOTE: placed after the case so its non-blocking assignments take precedence.
         if (launch) begin
            msg_q     <= msg_sel;
            row_q     <= 1'b0;
            col_q     <= '0;
            wait_q    <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            cs_q      <= 1'b1;
            wr_q      <= 1'b1;
            addr_q    <= ADDR_INSTR;
            if (CLEAR_ON_UPDATE != 0) begin
               state_q <= CLEAR;
               wdata_q <= INSTR_CLEAR;
            end else begin
               state_q <= ROW_ADDR;
               wdata_q <= INSTR_ROW0;
            end
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign address    = addr_q;
   assign chipselect = cs_q;
   assign write      = wr_q;
   assign writedata  = wdata_q;

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Scoreboard bench for lcd_msg_writer: a reference model queues the expected LCD writes
// per update, a monitor pops and compares each completed transfer and done pulse.
module tb_lcd_msg_writer;

   localparam int N_MSG        = 5;
   localparam int N_COLS       = 16;
   localparam int N_ROWS       = 2;
   localparam int WAIT_TIMEOUT = 7;

   typedef struct packed {
      logic       is_done;
      logic       addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       waitrequest = 1'b0;
   logic [2:0] msg_sel = 3'd0;
   logic       busy, done, error, address, chipselect, write;
   logic [7:0] writedata;

   int   n_vec = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   int   xfer_cnt = 0;
   int   wr_mode = 0;    // 0 no stall, 1 stall 3, 2 random stall, 3 stuck
   int   cur_msg = 0;

   string text [10] = '{"HELLO, WORLD!   ", "LCD MSG WRITER  ",
                        "MESSAGE ONE     ", "SECOND LINE 1   ",
                        "MESSAGE TWO     ", "SECOND LINE 2   ",
                        "STATUS: READY   ", "0123456789ABCDEF",
                        "ALARM: CHECK IO ", "abcdefghijklmnop"};

   lcd_msg_writer #(
      .N_MSG          (N_MSG),
      .N_COLS         (N_COLS),
      .N_ROWS         (N_ROWS),
      .CLEAR_ON_UPDATE(1),
      .AUTO_UPDATE    (1),
      .WAIT_TIMEOUT   (WAIT_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .msg_sel    (msg_sel),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_char(input int m, input int r, input int c);
      string s;
      if (m >= N_MSG) return 8'h20;
      s = text[2 * m + r];
      return s[c];
   endfunction

   task automatic push_update(input int m);
      exp_q.push_back(exp_t'{1'b0, 1'b0, 8'h01});
      for (int r = 0; r < N_ROWS; r++) begin
         exp_q.push_back(exp_t'{1'b0, 1'b0, (r == 0) ? 8'h80 : 8'hC0});
         for (int c = 0; c < N_COLS; c++) exp_q.push_back(exp_t'{1'b0, 1'b1, model_char(m, r, c)});
      end
      exp_q.push_back(exp_t'{1'b1, 1'b0, 8'h00});
   endtask

   task automatic wait_idle(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) ok = 1'b1;
      end
      check({name, "_complete"}, 32'(ok), 1);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic set_msg(input int m);
      @(posedge clk); #1 msg_sel = 3'(m);
   endtask

   // Controller model: decides waitrequest for each cycle just after the clock edge.
   int   stall_left;
   logic armed;
   initial begin
      stall_left = 0;
      armed      = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (wr_mode == 3) begin
            waitrequest = 1'b1;
         end else if (!chipselect) begin
            armed       = 1'b0;
            waitrequest = 1'b0;
         end else begin
            if (!armed) begin
               armed      = 1'b1;
               stall_left = (wr_mode == 1) ? 3 : (wr_mode == 2) ? int'($urandom_range(0, 4)) : 0;
            end else if (stall_left > 0) begin
               stall_left--;
            end
            waitrequest = (stall_left > 0);
         end
      end
   end

   // Monitor: transfer completion, gap cycle, stall stability, timeout abort, done timing.
   logic       prev_done, prev_stall, st_addr;
   logic [7:0] st_data;
   int         stall_run, since_xfer;
   exp_t       e;
   initial begin
      prev_done  = 1'b0;
      prev_stall = 1'b0;
      stall_run  = 0;
      since_xfer = 99;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_done  = 1'b0;
            prev_stall = 1'b0;
            stall_run  = 0;
            since_xfer = 99;
         end else begin
            since_xfer++;
            if (prev_done) check("gap_chipselect", 32'(chipselect), 0);
            if (prev_stall) begin
               if (stall_run <= WAIT_TIMEOUT)
                  check("stall_hold", {chipselect, write, address, writedata},
                        {2'b11, st_addr, st_data});
               else
                  check("timeout_abort cs/wr/err/busy", {chipselect, write, error, busy}, 4'b0010);
            end
            prev_done  = 1'b0;
            prev_stall = 1'b0;
            if (chipselect && write) begin
               check("busy_during_xfer", 32'(busy), 1);
               if (waitrequest) begin
                  stall_run++;
                  prev_stall = 1'b1;
                  st_addr    = address;
                  st_data    = writedata;
               end else begin
                  stall_run  = 0;
                  prev_done  = 1'b1;
                  since_xfer = 0;
                  xfer_cnt++;
                  check("write_expected", 32'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check("write_not_done_slot", 32'(e.is_done), 0);
                     check($sformatf("write%0d_addr_data", xfer_cnt), {address, writedata},
                           {e.addr, e.data});
                  end
               end
            end else begin
               stall_run = 0;
            end
            if (done) begin
               check("done_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("done_after_last_write", 32'(e.is_done), 1);
                  check("done_latency", since_xfer, 2);
               end
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int   base;
   logic found;
   int   fixed_msgs [3] = '{5, 4, 3};
   int   m;

   initial begin
      // Reset values and the automatic first update of msg 0.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_cs_wr", {chipselect, write}, 0);
      check("reset_busy_done_err", {busy, done, error}, 0);
      check("reset_addr_data", {address, writedata}, 0);
      push_update(0);
      cur_msg = 0;
      @(posedge clk); #1 reset = 1'b0;
      wait_idle("power_on_update");
      check("power_on_error", 32'(error), 0);

      // Three-cycle stall on every transfer, started by start with an unchanged msg_sel.
      wr_mode = 1;
      push_update(0);
      pulse_start();
      wait_idle("stall3_update");

      // msg_sel 1 -> 2 during transfer 10: pending update of msg 2 right after done.
      wr_mode = 0;
      push_update(1);
      push_update(2);
      base = xfer_cnt;
      set_msg(1);
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (chipselect && xfer_cnt == base + 9) found = 1'b1;
      end
      check("reach_transfer10", 32'(found), 1);
      msg_sel = 3'd2;
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (done) found = 1'b1;
      end
      check("first_done_seen", 32'(found), 1);
      @(negedge clk);
      check("restart_after_done", {chipselect, write, address, writedata}, {2'b11, 1'b0, 8'h01});
      wait_idle("pending_update");
      cur_msg = 2;

      // Controller stuck in waitrequest: abort after WAIT_TIMEOUT+1 stalled cycles.
      wr_mode = 3;
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (error) found = 1'b1;
      end
      check("timeout_error_seen", 32'(found), 1);
      repeat (10) @(negedge clk);
      check("after_abort err/busy/cs", {error, busy, chipselect}, 3'b100);
      wr_mode = 0;
      push_update(2);
      pulse_start();
      @(negedge clk);
      check("start_clears_error", 32'(error), 0);
      wait_idle("retry_update");

      // Out-of-range message, then a mix of random messages and stall patterns.
      wr_mode = 2;
      for (int i = 0; i < 7; i++) begin
         m = (i < 3) ? fixed_msgs[i] : int'($urandom_range(0, 7));
         push_update(m);
         if (m == cur_msg) pulse_start();
         else set_msg(m);
         wait_idle($sformatf("random_update%0d_msg%0d", i, m));
         cur_msg = m;
      end

      // Reset during CHAR drops chipselect at once; a full update follows release.
      wr_mode = 0;
      m = (cur_msg + 1) % N_MSG;
      push_update(m);
      base = xfer_cnt;
      set_msg(m);
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (chipselect && xfer_cnt >= base + 5) found = 1'b1;
      end
      check("reach_char_state", {31'(found), address}, {31'd1, 1'b1});
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid_xfer cs/wr/busy", {chipselect, write, busy}, 0);
      exp_q.delete();
      push_update(m);
      @(posedge clk); #1 reset = 1'b0;
      wait_idle("post_reset_update");

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
